// File: rtl/hazard_fwd_unit.sv
// Bypass and load-use hazard controller beside ID decode: tracks EX/MEM/WB destination
// records and picks the youngest in-flight producer for each ID source operand.
module hazard_fwd_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [XLEN-1:0]  mem_result,
    input  logic [XLEN-1:0]  wb_result,
    output logic             risk_con1,
    output logic             risk_con2,
    output logic [XLEN-1:0]  risk_rd1,
    output logic [XLEN-1:0]  risk_rd2,
    output logic             stall,
    output logic             bubble_ex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] fwd_cnt
);

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } stage_t;

    stage_t ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

    logic            con1_s, con2_s, lu1_s, lu2_s, stall_s, bubble_s;
    logic [XLEN-1:0] rd1_s, rd2_s;

    // x0 is hard-wired zero, so a record targeting it never matches
    function automatic logic hit(input stage_t p, input logic [4:0] s,
                                 input logic used, input logic valid);
        return p.v & p.we & (p.rd == s) & (s != 5'd0) & used & valid;
    endfunction

    // Source 1 bypass selection, youngest producer first
    always_comb begin
        con1_s = 1'b0;
        lu1_s  = 1'b0;
        rd1_s  = {XLEN{1'b0}};
        if (hit(ex_q, id_rs1, id_rs1_used, id_valid)) begin
            if (ex_q.ld) begin
                lu1_s = 1'b1;
            end else begin
                con1_s = 1'b1;
                rd1_s  = ex_result;
            end
        end else if (hit(mem_q, id_rs1, id_rs1_used, id_valid)) begin
            con1_s = 1'b1;
            rd1_s  = mem_result;
        end else if (hit(wb_q, id_rs1, id_rs1_used, id_valid)) begin
            con1_s = 1'b1;
            rd1_s  = wb_result;
        end else begin
            con1_s = 1'b0;
        end
    end

    // Source 2 bypass selection, youngest producer first
    always_comb begin
        con2_s = 1'b0;
        lu2_s  = 1'b0;
        rd2_s  = {XLEN{1'b0}};
        if (hit(ex_q, id_rs2, id_rs2_used, id_valid)) begin
            if (ex_q.ld) begin
                lu2_s = 1'b1;
            end else begin
                con2_s = 1'b1;
                rd2_s  = ex_result;
            end
        end else if (hit(mem_q, id_rs2, id_rs2_used, id_valid)) begin
            con2_s = 1'b1;
            rd2_s  = mem_result;
        end else if (hit(wb_q, id_rs2, id_rs2_used, id_valid)) begin
            con2_s = 1'b1;
            rd2_s  = wb_result;
        end else begin
            con2_s = 1'b0;
        end
    end

    // Flush kills the ID instruction anyway, so it overrides a load-use stall
    always_comb begin
        stall_s  = (lu1_s | lu2_s) & ~flush;
        bubble_s = lu1_s | lu2_s | flush;
        if (id_valid & ~stall_s & ~flush) begin
            ex_d = '{v: 1'b1, rd: id_rd, we: id_we, ld: id_is_load};
        end else begin
            ex_d = '0;
        end
    end

    // Saturating counter next-state
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if ((con1_s | con2_s) && (fwd_cnt_q != {CNT_W{1'b1}})) begin
            fwd_cnt_d = fwd_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            fwd_cnt_d = fwd_cnt_q;
        end
    end

    // Stage records and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= {CNT_W{1'b0}};
            fwd_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            wb_q        <= mem_q;
            mem_q       <= ex_q;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign risk_con1 = con1_s;
    assign risk_con2 = con2_s;
    assign risk_rd1  = rd1_s;
    assign risk_rd2  = rd2_s;
    assign stall     = stall_s;
    assign bubble_ex = bubble_s;
    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule
